// File: rtl/div_seq_ctrl_if.sv
// rtl/div_seq_ctrl_if.sv - EX-stage handshake bundle between pipeline control and the divide sequencer
//
// Signals:
//   start_EX  master->slave  divide-class instruction valid in EX
//   op_EX     master->slave  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend  master->slave  rs1 value
//   divisor   master->slave  rs2 value
//   flush_EX  master->slave  kill in-flight op
//   stall_EX  slave->master  hold PC/IF/EX registers
//   busy      slave->master  sequencer not idle
//   done      slave->master  one-cycle result-valid pulse
//   result    slave->master  registered quotient or remainder
interface div_seq_ctrl_if #(
    parameter int XLEN = 32
);
    logic            start_EX;
    logic [1:0]      op_EX;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            flush_EX;
    logic            stall_EX;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start_EX, op_EX, dividend, divisor, flush_EX,
        input  stall_EX, busy, done, result
    );

    modport slave (
        input  start_EX, op_EX, dividend, divisor, flush_EX,
        output stall_EX, busy, done, result
    );
endinterface

// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - restoring radix-2 RV32M divide/remainder sequencer for the EX stage
//
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    div_seq_ctrl_if.slave: start_EX/op_EX/dividend/divisor/flush_EX in,
//          stall_EX/busy/done/result out
module div_seq_ctrl #(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    div_seq_ctrl_if.slave    bus
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [1:0]      r_op;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [XLEN-1:0] r_quot;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_dvsr;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_result;

    logic            w_stall;
    logic            w_done;
    logic            w_accept;
    logic            w_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div0;
    logic            w_ovf;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_trial;
    logic            w_qbit;
    logic [XLEN-1:0] w_rem_n;
    logic [XLEN-1:0] w_quot_n;
    logic [XLEN-1:0] w_final;

    // op_EX[0]=1 selects the unsigned variants
    assign w_signed = ~bus.op_EX[0];
    assign w_a_neg  = w_signed & bus.dividend[XLEN-1];
    assign w_b_neg  = w_signed & bus.divisor[XLEN-1];
    assign w_a_mag  = w_a_neg ? (~bus.dividend + 1'b1) : bus.dividend;
    assign w_b_mag  = w_b_neg ? (~bus.divisor + 1'b1) : bus.divisor;
    assign w_div0   = (bus.divisor == '0);
    assign w_ovf    = w_signed && (bus.dividend == {1'b1, {(XLEN-1){1'b0}}})
                      && (bus.divisor == '1);
    assign w_accept = (r_state == IDLE) & bus.start_EX & ~bus.flush_EX;

    // One restoring step: the dividend bits shift out of r_quot into the
    // partial remainder while quotient bits shift in from the bottom.
    assign w_shift  = {r_rem, r_quot[XLEN-1]};
    assign w_trial  = w_shift - {1'b0, r_dvsr};
    assign w_qbit   = ~w_trial[XLEN];
    assign w_rem_n  = w_qbit ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
    assign w_quot_n = {r_quot[XLEN-2:0], w_qbit};

    always_comb begin
        w_final = w_quot_n;
        if (r_op[1]) begin
            w_final = (r_neg_r && !r_op[0]) ? (~w_rem_n + 1'b1) : w_rem_n;
        end else begin
            w_final = (r_neg_q && !r_op[0]) ? (~w_quot_n + 1'b1) : w_quot_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_stall = 1'b1;
                    w_next  = (w_div0 || w_ovf) ? DONE : RUN;
                end
            end
            RUN: begin
                w_stall = 1'b1;
                if (r_cnt == CW'(1)) w_next = DONE;
            end
            DONE: begin
                // start_EX is still the retiring instruction here, so never re-accept
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (bus.flush_EX) w_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_quot   <= '0;
            r_rem    <= '0;
            r_dvsr   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op    <= bus.op_EX;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_quot  <= w_a_mag;
            r_rem   <= '0;
            r_dvsr  <= w_b_mag;
            r_cnt   <= CW'(XLEN);
            // Special cases skip RUN, so their result is written on the accept edge
            if (w_div0) begin
                r_result <= bus.op_EX[1] ? bus.dividend : '1;
            end else if (w_ovf) begin
                r_result <= bus.op_EX[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            end
        end else if (r_state == RUN && !bus.flush_EX) begin
            r_quot <= w_quot_n;
            r_rem  <= w_rem_n;
            r_cnt  <= r_cnt - 1'b1;
            if (r_cnt == CW'(1)) r_result <= w_final;
        end
    end

    assign bus.stall_EX = w_stall;
    assign bus.busy     = (r_state != IDLE);
    assign bus.done     = w_done;
    assign bus.result   = r_result;
endmodule
